// File: rtl/useq_pkg.sv
// Shared encodings for the microsequencer controller: next-address opcodes,
// slice source selects and din source selects.
package useq_pkg;

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } useq_op_e;

    localparam logic [1:0] SRC_UPC   = 2'b00;
    localparam logic [1:0] SRC_AREG  = 2'b01;
    localparam logic [1:0] SRC_STACK = 2'b10;
    localparam logic [1:0] SRC_DIN   = 2'b11;

    localparam logic [1:0] DSEL_BR  = 2'd0;
    localparam logic [1:0] DSEL_MAP = 2'd1;
    localparam logic [1:0] DSEL_VEC = 2'd2;

endpackage

// File: rtl/useq_dec.sv
// Combinational next-address decoder: maps the registered opcode, condition result
// and loop-counter state onto am2911 slice controls and counter strobes.
module useq_dec
    import useq_pkg::*;
(
    input  logic [3:0] i,
    input  logic       pass,
    input  logic       cnt_zero,
    input  logic       hold_,
    output logic [1:0] s,
    output logic       fe_,
    output logic       pup,
    output logic       re_,
    output logic       zero_,
    output logic       cn,
    output logic [1:0] dsel,
    output logic       cnt_clr,
    output logic       cnt_ld,
    output logic       cnt_dec
);

    useq_op_e op;
    assign op = useq_op_e'(i);

    always_comb begin
        s       = SRC_UPC;
        fe_     = 1'b1;
        pup     = 1'b0;
        re_     = 1'b1;
        zero_   = 1'b1;
        cn      = 1'b1;
        dsel    = DSEL_BR;
        cnt_clr = 1'b0;
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;

        // Stall: re-emit the current address with no side effects.
        if (!hold_) begin
            cn = 1'b0;
        end else begin
            unique case (op)
                JZ: begin
                    zero_   = 1'b0;
                    cnt_clr = 1'b1;
                end
                CJS: begin
                    if (pass) begin
                        s   = SRC_DIN;
                        fe_ = 1'b0;
                        pup = 1'b1;
                    end
                end
                JMAP: begin
                    s    = SRC_DIN;
                    dsel = DSEL_MAP;
                end
                CJP: begin
                    if (pass) s = SRC_DIN;
                end
                PUSH: begin
                    fe_    = 1'b0;
                    pup    = 1'b1;
                    cnt_ld = pass;
                end
                JSRP: begin
                    fe_ = 1'b0;
                    pup = 1'b1;
                    s   = pass ? SRC_DIN : SRC_AREG;
                end
                CJV: begin
                    if (pass) begin
                        s    = SRC_DIN;
                        dsel = DSEL_VEC;
                    end
                end
                JRP: begin
                    s = pass ? SRC_DIN : SRC_AREG;
                end
                RFCT: begin
                    if (!cnt_zero) begin
                        s       = SRC_STACK;
                        cnt_dec = 1'b1;
                    end else begin
                        fe_ = 1'b0;
                    end
                end
                RPCT: begin
                    if (!cnt_zero) begin
                        s       = SRC_DIN;
                        cnt_dec = 1'b1;
                    end
                end
                CRTN: begin
                    if (pass) begin
                        s   = SRC_STACK;
                        fe_ = 1'b0;
                    end
                end
                CJPP: begin
                    if (pass) begin
                        s   = SRC_DIN;
                        fe_ = 1'b0;
                    end
                end
                LDCT: begin
                    cnt_ld = 1'b1;
                    re_    = 1'b0;
                end
                LOOP: begin
                    if (pass) fe_ = 1'b0;
                    else      s   = SRC_STACK;
                end
                CONT: begin
                end
                TWB: begin
                    if (pass) begin
                        fe_ = 1'b0;
                    end else if (!cnt_zero) begin
                        s       = SRC_STACK;
                        cnt_dec = 1'b1;
                    end else begin
                        s   = SRC_DIN;
                        fe_ = 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/useq_ctl.sv
// Microinstruction pipeline register, condition mux and loop counter driving a
// cascade of am2911 slices; all state advances on the falling edge of cp.
module useq_ctl
    import useq_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             cp,
    input  logic             rst_,
    input  logic [3:0]       mi_i,
    input  logic             mi_pol,
    input  logic [2:0]       mi_csel,
    input  logic [WIDTH-1:0] mi_d,
    input  logic [7:0]       cc,
    input  logic             hold_,
    output logic [WIDTH-1:0] br,
    output logic [1:0]       dsel,
    output logic [1:0]       s,
    output logic             fe_,
    output logic             pup,
    output logic             re_,
    output logic             zero_,
    output logic             cn,
    output logic             cnt_zero
);

    logic [3:0]       i_q;
    logic             pol_q;
    logic [2:0]       csel_q;
    logic [WIDTH-1:0] br_q;
    logic [WIDTH-1:0] cnt_q;

    logic pass;
    logic hold_eff_;
    logic cnt_clr;
    logic cnt_ld;
    logic cnt_dec;

    always_ff @(negedge cp or negedge rst_) begin
        if (!rst_) begin
            i_q    <= JZ;
            pol_q  <= 1'b0;
            csel_q <= 3'd0;
            br_q   <= '0;
        end else if (hold_) begin
            i_q    <= mi_i;
            pol_q  <= mi_pol;
            csel_q <= mi_csel;
            br_q   <= mi_d;
        end
    end

    // Strobes are already suppressed by the decoder while holding.
    always_ff @(negedge cp or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_ld) begin
            cnt_q <= br_q;
        end else if (cnt_dec) begin
            cnt_q <= cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign pass     = cc[csel_q] ^ pol_q;
    assign cnt_zero = (cnt_q == '0);
    assign br       = br_q;

    // Reset outranks a stall so the outputs show the JZ decode during reset.
    assign hold_eff_ = hold_ | ~rst_;

    useq_dec u_dec (
        .i        (i_q),
        .pass     (pass),
        .cnt_zero (cnt_zero),
        .hold_    (hold_eff_),
        .s        (s),
        .fe_      (fe_),
        .pup      (pup),
        .re_      (re_),
        .zero_    (zero_),
        .cn       (cn),
        .dsel     (dsel),
        .cnt_clr  (cnt_clr),
        .cnt_ld   (cnt_ld),
        .cnt_dec  (cnt_dec)
    );

endmodule

// File: tb/tb_useq_ctl.sv
// Randomised scoreboard bench for useq_ctl: a behavioural sequencer model predicts
// each cycle's slice controls and a monitor compares them against the DUT.
module tb_useq_ctl;

    localparam int W = 12;

    logic          cp = 1'b1;
    logic          rst_;
    logic [3:0]    mi_i;
    logic          mi_pol;
    logic [2:0]    mi_csel;
    logic [W-1:0]  mi_d;
    logic [7:0]    cc;
    logic          hold_;
    logic [W-1:0]  br;
    logic [1:0]    dsel;
    logic [1:0]    s;
    logic          fe_, pup, re_, zero_, cn, cnt_zero;

    useq_ctl #(.WIDTH(W)) dut (
        .cp       (cp),
        .rst_     (rst_),
        .mi_i     (mi_i),
        .mi_pol   (mi_pol),
        .mi_csel  (mi_csel),
        .mi_d     (mi_d),
        .cc       (cc),
        .hold_    (hold_),
        .br       (br),
        .dsel     (dsel),
        .s        (s),
        .fe_      (fe_),
        .pup      (pup),
        .re_      (re_),
        .zero_    (zero_),
        .cn       (cn),
        .cnt_zero (cnt_zero)
    );

    always #5 cp = ~cp;

    typedef struct packed {
        logic [1:0]   s;
        logic         fe_;
        logic         pup;
        logic         re_;
        logic         zero_;
        logic         cn;
        logic [1:0]   dsel;
        logic [W-1:0] br;
        logic         cnt_zero;
    } obs_t;

    typedef struct {
        obs_t  e;
        string tag;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    // Reference state: the microword being executed and the loop count.
    int       m_op, m_csel, m_br, m_cnt;
    logic     m_pol;
    logic     in_reset;
    logic [7:0] cur_cc;
    logic     cur_hold;

    // Expected slice behaviour written as "where does the next address come from,
    // what happens to the stack", straight from the instruction table.
    function automatic obs_t model_out(int op, logic pass, int cnt, logic hold, int brv);
        string src, stk;
        obs_t  o;
        int    dsv;
        logic  zr, rl;
        src = "upc"; stk = "none"; dsv = 0; zr = 1'b1; rl = 1'b1;
        if (hold) begin
            case (op)
                0:  zr = 1'b0;
                1:  if (pass) begin src = "din"; stk = "push"; end
                2:  begin src = "din"; dsv = 1; end
                3:  if (pass) src = "din";
                4:  stk = "push";
                5:  begin stk = "push"; src = pass ? "din" : "areg"; end
                6:  if (pass) begin src = "din"; dsv = 2; end
                7:  src = pass ? "din" : "areg";
                8:  if (cnt != 0) src = "stack"; else stk = "pop";
                9:  if (cnt != 0) src = "din";
                10: if (pass) begin src = "stack"; stk = "pop"; end
                11: if (pass) begin src = "din"; stk = "pop"; end
                12: rl = 1'b0;
                13: if (pass) stk = "pop"; else src = "stack";
                15: if (pass) stk = "pop";
                    else if (cnt != 0) src = "stack";
                    else begin src = "din"; stk = "pop"; end
                default: ;
            endcase
        end
        case (src)
            "areg":  o.s = 2'b01;
            "stack": o.s = 2'b10;
            "din":   o.s = 2'b11;
            default: o.s = 2'b00;
        endcase
        o.fe_      = (stk == "none");
        o.pup      = (stk == "push");
        o.re_      = rl;
        o.zero_    = zr;
        o.cn       = hold;
        o.dsel     = 2'(dsv);
        o.br       = W'(brv);
        o.cnt_zero = (cnt == 0);
        return o;
    endfunction

    function automatic int model_cnt(int op, logic pass, int cnt, int brv);
        case (op)
            0:  return 0;
            4:  return pass ? brv : cnt;
            8, 9: return (cnt != 0) ? cnt - 1 : cnt;
            12: return brv;
            15: return (!pass && cnt != 0) ? cnt - 1 : cnt;
            default: return cnt;
        endcase
    endfunction

    function automatic logic model_pass();
        return cur_cc[m_csel] ^ m_pol;
    endfunction

    task automatic push_expect(input string tag);
        sb_t e;
        if (in_reset) begin
            e.e = '{s: 2'b00, fe_: 1'b1, pup: 1'b0, re_: 1'b1, zero_: 1'b0, cn: 1'b1,
                    dsel: 2'd0, br: '0, cnt_zero: 1'b1};
        end else begin
            e.e = model_out(m_op, model_pass(), m_cnt, cur_hold, m_br);
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Present a microword for capture at the next falling edge, then drive the
    // condition inputs and stall request seen while that word executes.
    task automatic run(input int op, input logic pol, input int csel, input int d,
                       input logic [7:0] ccv, input logic holdv, input string tag);
        mi_i    = 4'(op);
        mi_pol  = pol;
        mi_csel = 3'(csel);
        mi_d    = W'(d);
        @(negedge cp);
        if (cur_hold) begin
            m_cnt  = model_cnt(m_op, model_pass(), m_cnt, m_br);
            m_op   = op;
            m_pol  = pol;
            m_csel = csel;
            m_br   = d;
        end
        in_reset = 1'b0;
        #1;
        cc       = ccv;
        hold_    = holdv;
        cur_cc   = ccv;
        cur_hold = holdv;
        #1;
        push_expect(tag);
    endtask

    task automatic do_reset(input logic holdv);
        @(posedge cp);
        #1;
        rst_     = 1'b0;
        hold_    = holdv;
        cur_hold = holdv;
        in_reset = 1'b1;
        m_op = 0; m_pol = 1'b0; m_csel = 0; m_br = 0; m_cnt = 0;
        #1;
        push_expect("reset");
        @(posedge cp);
        #1;
        rst_ = 1'b1;
    endtask

    always @(posedge cp) begin
        if (sb.size() > 0) begin
            sb_t  e;
            obs_t a;
            e = sb.pop_front();
            a = '{s: s, fe_: fe_, pup: pup, re_: re_, zero_: zero_, cn: cn,
                  dsel: dsel, br: br, cnt_zero: cnt_zero};
            n_cmp++;
            if (a !== e.e) begin
                n_err++;
                $display("FAIL %s: got s=%b fe_=%b pup=%b re_=%b zero_=%b cn=%b dsel=%0d br=%h cz=%b, expected s=%b fe_=%b pup=%b re_=%b zero_=%b cn=%b dsel=%0d br=%h cz=%b",
                         e.tag, a.s, a.fe_, a.pup, a.re_, a.zero_, a.cn, a.dsel, a.br,
                         a.cnt_zero, e.e.s, e.e.fe_, e.e.pup, e.e.re_, e.e.zero_, e.e.cn,
                         e.e.dsel, e.e.br, e.e.cnt_zero);
            end
        end
    end

    initial begin
        rst_ = 1'b0; hold_ = 1'b1; cc = 8'h00;
        mi_i = 4'd0; mi_pol = 1'b0; mi_csel = 3'd0; mi_d = '0;
        cur_cc = 8'h00; cur_hold = 1'b1; in_reset = 1'b1;
        m_op = 0; m_pol = 1'b0; m_csel = 0; m_br = 0; m_cnt = 0;
        #1;
        push_expect("reset_init");
        @(posedge cp);
        #1;
        rst_ = 1'b1;

        // Reset in the middle of an RFCT loop.
        run(12, 0, 0, 5, 8'h00, 1'b1, "ldct5");
        run(8, 0, 0, 0, 8'h00, 1'b1, "rfct_pre_reset");
        do_reset(1'b1);
        run(14, 0, 0, 0, 8'h00, 1'b1, "cont_after_reset");

        // CJS taken / not taken.
        run(1, 0, 3, 12'h123, 8'h08, 1'b1, "cjs_pass");
        run(1, 0, 3, 12'h123, 8'h00, 1'b1, "cjs_fail");

        // LDCT 2 then three RFCTs.
        run(12, 0, 0, 2, 8'h00, 1'b1, "ldct2");
        run(8, 0, 0, 0, 8'h00, 1'b1, "rfct1");
        run(8, 0, 0, 0, 8'h00, 1'b1, "rfct2");
        run(8, 0, 0, 0, 8'h00, 1'b1, "rfct3");

        // TWB: count 1 fail, fail at zero, then pass.
        run(12, 0, 0, 1, 8'h00, 1'b1, "ldct1");
        run(15, 0, 5, 0, 8'h00, 1'b1, "twb_fail_nz");
        run(15, 0, 5, 0, 8'h00, 1'b1, "twb_fail_z");
        run(15, 1, 5, 0, 8'h00, 1'b1, "twb_pass");

        // Hold three cycles during CJP; intervening words must be dropped.
        run(3, 0, 2, 12'h0ab, 8'h04, 1'b0, "cjp_hold1");
        run(1, 0, 0, 12'hfff, 8'h04, 1'b0, "cjp_hold2");
        run(12, 0, 0, 12'h777, 8'h04, 1'b0, "cjp_hold3");
        run(0, 0, 0, 12'h000, 8'h04, 1'b1, "cjp_resume");

        // JMAP and CJV both ways.
        run(2, 0, 0, 12'h055, 8'h00, 1'b1, "jmap");
        run(6, 1, 7, 12'h066, 8'h00, 1'b1, "cjv_pass");
        run(6, 0, 7, 12'h066, 8'h00, 1'b1, "cjv_fail");

        // Randomised sequences, with occasional resets (some asserted during a stall).
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            run(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                8'($urandom), ($urandom_range(0, 5) != 0), "random");
        end

        // Let the monitor drain, bounded.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge cp);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
